// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction-ROM path. Takes a framed byte
// stream (0xA5, LEN, ADDR, LEN data bytes, CHK) over valid/ready and writes
// the data bytes into program memory. The CPU is held in reset while a frame
// loads and is released only after the frame checksum verifies.
//
// state | meaning
// ------+-------------------------------------------------------------------
// HUNT  | idle; waiting for the 0xA5 header, any other byte is dropped
// LEN   | next beat is the data length (0 means 256 bytes)
// ADDR  | next beat is the start address (low ADDR_W bits kept)
// DATA  | data beats; each one is written to memory on the following cycle
// CHK   | next beat is the checksum byte
// HOLD  | checksum good; cpu_rst_n kept low for HOLD_CYC more cycles
module prog_loader #(
  parameter int ADDR_W   = 8,
  parameter int HOLD_CYC = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  // Down-counters hold "remaining cycles minus one", so the widths only need
  // to cover TIMEOUT-1 and HOLD_CYC-1.
  localparam int IDLE_W = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [7:0]        HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_LEN  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [8:0]        byte_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        sum;

  logic              beat;
  logic              framed;
  logic              idle_expired;
  logic              hdr_seen;
  logic              last_data;
  logic [7:0]        chk_sum;
  logic              chk_good;
  logic              hold_done;
  logic              ok_nxt;
  logic              err_nxt;

  assign beat      = in_valid & in_ready;
  assign framed    = (state == S_LEN) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CHK);
  // The idle limit is reached only on a cycle without a beat, so a beat that
  // lands exactly on the limit still counts.
  assign idle_expired = framed && !beat && (idle_cnt == '0);
  assign hdr_seen  = (state == S_HUNT) && beat && (in_data == HDR_BYTE);
  assign last_data = (byte_cnt == 9'd1);
  assign chk_sum   = sum + in_data;
  assign chk_good  = (chk_sum == 8'h00);
  assign hold_done = (state == S_HOLD) && (hold_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT: begin
        if (hdr_seen) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (beat)              state_nxt = S_ADDR;
        else if (idle_expired) state_nxt = S_HUNT;
      end
      S_ADDR: begin
        if (beat)              state_nxt = S_DATA;
        else if (idle_expired) state_nxt = S_HUNT;
      end
      S_DATA: begin
        if (beat && last_data) state_nxt = S_CHK;
        else if (idle_expired) state_nxt = S_HUNT;
      end
      S_CHK: begin
        if (beat)              state_nxt = chk_good ? S_HOLD : S_HUNT;
        else if (idle_expired) state_nxt = S_HUNT;
      end
      S_HOLD: begin
        if (hold_done) state_nxt = S_HUNT;
      end
      default: state_nxt = S_HUNT;
    endcase
  end

  // Output decode: handshake, busy flag and next values of the status pulses
  always_comb begin
    in_ready = (state != S_HOLD);
    busy     = (state != S_HUNT);
    ok_nxt   = hold_done;
    err_nxt  = idle_expired || ((state == S_CHK) && beat && !chk_good);
  end

  // Inter-beat idle timer, reloaded on every accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= IDLE_LOAD;
    end else if (beat) begin
      idle_cnt <= IDLE_LOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  // Post-checksum hold timer, armed by the checksum beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == S_CHK) && beat) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Frame bookkeeping: remaining byte count, write pointer, running sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      ptr      <= '0;
      sum      <= '0;
    end else if (beat) begin
      case (state)
        S_LEN: begin
          byte_cnt <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          sum      <= '0;
        end
        S_ADDR: begin
          ptr <= in_data[ADDR_W-1:0];
        end
        S_DATA: begin
          byte_cnt <= byte_cnt - 9'd1;
          ptr      <= ptr + ADDR_W'(1);
          sum      <= chk_sum;
        end
        default: ;
      endcase
    end
  end

  // Registered memory write port: one strobe per accepted data beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= (state == S_DATA) && beat;
      if ((state == S_DATA) && beat) begin
        mem_addr  <= ptr;
        mem_wdata <= in_data;
      end
    end
  end

  // CPU reset: pulled low when a header is taken, released after the hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst_n <= 1'b0;
    end else if (hdr_seen) begin
      cpu_rst_n <= 1'b0;
    end else if (ok_nxt) begin
      cpu_rst_n <= 1'b1;
    end
  end

  // Status pulses, one cycle each
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ok  <= ok_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives framed byte streams with random gaps into
// prog_loader and checks memory writes, status pulses and CPU reset timing
// against expectations computed from each frame's contents.
module tb_prog_loader;

  localparam int ADDR_W   = 8;
  localparam int HOLD_CYC = 4;
  localparam int TIMEOUT  = 30;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              load_ok;
  logic              load_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  prog_loader #(
    .ADDR_W   (ADDR_W),
    .HOLD_CYC (HOLD_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Rising-edge count; an event seen at a falling edge belongs to edge "cyc"
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, each tagged with the rising edge that produced it
  int   wr_cyc[$];
  int   wr_addr[$];
  int   wr_data[$];
  int   ok_cyc[$];
  int   err_cyc[$];
  int   rise_cyc[$];
  logic prev_rst_n = 1'b0;

  // Monitor: sample DUT outputs on the falling edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
    end
    if (load_ok === 1'b1)  ok_cyc.push_back(cyc);
    if (load_err === 1'b1) err_cyc.push_back(cyc);
    if (cpu_rst_n === 1'b1 && prev_rst_n !== 1'b1) rise_cyc.push_back(cyc);
    prev_rst_n = cpu_rst_n;
  end

  logic [7:0] pre_q[$];
  logic [7:0] dat_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    ok_cyc.delete();
    err_cyc.delete();
    rise_cyc.delete();
    @(negedge clk);
  endtask

  // Present one byte after "gap" idle cycles; acc = rising edge that took it.
  // Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check_eq("ready_wait", in_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Send pre_q garbage, then a full frame with dat_q as payload, and check
  // every write, pulse and the CPU reset release against the frame contents.
  task automatic run_frame(input logic [7:0] len_b, input logic [7:0] addr_b,
                           input logic [7:0] chk_b, input int max_gap, input string tag);
    int         acc;
    int         e_acc;
    int         dacc[$];
    logic [7:0] s;
    int         good;
    clear_mon();
    foreach (pre_q[i]) send_byte(pre_q[i], $urandom_range(0, max_gap), acc);
    send_byte(8'hA5, $urandom_range(0, max_gap), acc);
    check_eq({tag, "/hdr_cpu_rst_n"}, cpu_rst_n, 0);
    check_eq({tag, "/hdr_busy"}, busy, 1);
    send_byte(len_b, $urandom_range(0, max_gap), acc);
    send_byte(addr_b, $urandom_range(0, max_gap), acc);
    foreach (dat_q[i]) begin
      send_byte(dat_q[i], $urandom_range(0, max_gap), acc);
      dacc.push_back(acc);
    end
    send_byte(chk_b, $urandom_range(0, max_gap), e_acc);
    repeat (HOLD_CYC + 4) @(negedge clk);

    s = chk_b;
    foreach (dat_q[i]) s = s + dat_q[i];
    good = (s == 8'h00) ? 1 : 0;

    check_eq({tag, "/n_writes"}, wr_cyc.size(), dat_q.size());
    for (int i = 0; i < dat_q.size() && i < wr_cyc.size(); i++) begin
      check_eq({tag, "/wr_addr"}, wr_addr[i], (int'(addr_b) + i) % (1 << ADDR_W));
      check_eq({tag, "/wr_data"}, wr_data[i], dat_q[i]);
      check_eq({tag, "/wr_cycle"}, wr_cyc[i], dacc[i]);
    end
    check_eq({tag, "/n_ok"}, ok_cyc.size(), good);
    check_eq({tag, "/n_err"}, err_cyc.size(), 1 - good);
    check_eq({tag, "/n_release"}, rise_cyc.size(), good);
    if (good == 1) begin
      if (ok_cyc.size() > 0)   check_eq({tag, "/ok_cycle"}, ok_cyc[0], e_acc + HOLD_CYC);
      if (rise_cyc.size() > 0) check_eq({tag, "/release_cycle"}, rise_cyc[0], e_acc + HOLD_CYC);
    end else begin
      if (err_cyc.size() > 0) check_eq({tag, "/err_cycle"}, err_cyc[0], e_acc);
    end
    check_eq({tag, "/cpu_rst_n"}, cpu_rst_n, good);
    check_eq({tag, "/busy_end"}, busy, 0);
    check_eq({tag, "/in_ready_end"}, in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/in_ready"}, in_ready, 1);
    check_eq({tag, "/mem_we"}, mem_we, 0);
    check_eq({tag, "/mem_addr"}, mem_addr, 0);
    check_eq({tag, "/mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "/cpu_rst_n"}, cpu_rst_n, 0);
    check_eq({tag, "/busy"}, busy, 0);
    check_eq({tag, "/load_ok"}, load_ok, 0);
    check_eq({tag, "/load_err"}, load_err, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int         acc;
    int         len;
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] chk;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    pre_q = {};
    dat_q = {8'h11, 8'h22, 8'h33};
    run_frame(8'h03, 8'h10, 8'h9A, 0, "t1");
    run_frame(8'h03, 8'h10, 8'h9B, 0, "t2");
    dat_q = {8'h01, 8'h02};
    run_frame(8'h02, 8'hFF, 8'hFD, 0, "t3");

    // Frame stalls after one data byte until the idle limit aborts it
    clear_mon();
    send_byte(8'hA5, 0, acc);
    send_byte(8'h05, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'hAA, 0, acc);
    repeat (TIMEOUT + 3) @(negedge clk);
    check_eq("t4/n_writes", wr_cyc.size(), 1);
    if (wr_cyc.size() > 0) begin
      check_eq("t4/wr_addr", wr_addr[0], 0);
      check_eq("t4/wr_data", wr_data[0], 8'hAA);
      check_eq("t4/wr_cycle", wr_cyc[0], acc);
    end
    check_eq("t4/n_err", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check_eq("t4/err_cycle", err_cyc[0], acc + TIMEOUT);
    check_eq("t4/n_ok", ok_cyc.size(), 0);
    check_eq("t4/busy", busy, 0);
    check_eq("t4/cpu_rst_n", cpu_rst_n, 0);
    check_eq("t4/in_ready", in_ready, 1);

    pre_q = {8'h00, 8'h5A};
    dat_q = {8'h11, 8'h22, 8'h33};
    run_frame(8'h03, 8'h10, 8'h9A, 3, "t5");

    // 256-byte frame (LEN = 0)
    pre_q = {};
    dat_q.delete();
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      dat_q.push_back(b);
      s = s + b;
    end
    run_frame(8'h00, 8'($urandom_range(0, 255)), 8'h00 - s, 0, "t6_len256");

    // Asynchronous reset in the middle of the data phase
    clear_mon();
    send_byte(8'hA5, 0, acc);
    send_byte(8'h0A, 0, acc);
    send_byte(8'h20, 0, acc);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 0, acc);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dat_q = {8'hC3, 8'h3C};
    run_frame(8'h02, 8'h80, 8'h01, 2, "t6_after_rst");

    // Randomized frames: lengths, addresses, payloads, garbage and gaps
    for (int f = 0; f < 20; f++) begin
      pre_q.delete();
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        pre_q.push_back(b);
      end
      len = $urandom_range(1, 24);
      dat_q.delete();
      s = 8'h00;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        dat_q.push_back(b);
        s = s + b;
      end
      chk = 8'h00 - s;
      if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
      run_frame(8'(len), 8'($urandom_range(0, 255)), chk, 3, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
